// File: rtl/tawas_ls_if.sv
// tawas_ls_if: signal bundle between the load/store stage and its neighbours.
//
//   Fetch side       : SLICE, LS_OP_VLD, LS_OP
//   Register file    : REG_PTR_SEL, REG_DATA_SEL, PTR_DATA, STORE_DATA
//   Data-RAM bus     : DCS, DWR, DADDR, DMASK, DOUT, DIN
//   Load write-back  : WB_VLD, WB_SLICE, WB_REG, WB_DATA
//   Pointer update   : PTR_WB_VLD, PTR_WB_SLICE, PTR_WB_REG, PTR_WB_DATA
//   Fault report     : LS_FAULT, FAULT_SLICE
//
// modport master is the load/store stage; modport slave is everything around it.
interface tawas_ls_if;
  logic        SLICE;
  logic        LS_OP_VLD;
  logic [14:0] LS_OP;
  logic [2:0]  REG_PTR_SEL;
  logic [2:0]  REG_DATA_SEL;
  logic [31:0] PTR_DATA;
  logic [31:0] STORE_DATA;
  logic        DCS;
  logic        DWR;
  logic [31:0] DADDR;
  logic [3:0]  DMASK;
  logic [31:0] DOUT;
  logic [31:0] DIN;
  logic        WB_VLD;
  logic        WB_SLICE;
  logic [2:0]  WB_REG;
  logic [31:0] WB_DATA;
  logic        PTR_WB_VLD;
  logic        PTR_WB_SLICE;
  logic [2:0]  PTR_WB_REG;
  logic [31:0] PTR_WB_DATA;
  logic        LS_FAULT;
  logic        FAULT_SLICE;

  modport master (
    input  SLICE, LS_OP_VLD, LS_OP, PTR_DATA, STORE_DATA, DIN,
    output REG_PTR_SEL, REG_DATA_SEL,
    output DCS, DWR, DADDR, DMASK, DOUT,
    output WB_VLD, WB_SLICE, WB_REG, WB_DATA,
    output PTR_WB_VLD, PTR_WB_SLICE, PTR_WB_REG, PTR_WB_DATA,
    output LS_FAULT, FAULT_SLICE
  );

  modport slave (
    output SLICE, LS_OP_VLD, LS_OP, PTR_DATA, STORE_DATA, DIN,
    input  REG_PTR_SEL, REG_DATA_SEL,
    input  DCS, DWR, DADDR, DMASK, DOUT,
    input  WB_VLD, WB_SLICE, WB_REG, WB_DATA,
    input  PTR_WB_VLD, PTR_WB_SLICE, PTR_WB_REG, PTR_WB_DATA,
    input  LS_FAULT, FAULT_SLICE
  );
endinterface

// File: rtl/tawas_ls.sv
// tawas_ls: load/store execution stage.
//
// Accepts one op per clock from fetch (no stall), reads pointer/store data
// from the register file in the same cycle, and issues a single-cycle access
// on the synchronous data-RAM bus one cycle later. Loads return formatted data
// two cycles after acceptance; post-increment / pre-update ops return the new
// pointer one cycle after acceptance. Misaligned ops raise LS_FAULT instead.
//
// Ports:
//   CLK    clock
//   RST_N  asynchronous active-low reset
//   bus    tawas_ls_if.master (fetch op, register-file reads, data bus,
//          load write-back, pointer write-back, fault report)
//
// Parameter RAM_LAT: data-RAM read latency; only 1 is supported.
module tawas_ls #(
  parameter int RAM_LAT = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  tawas_ls_if.master   bus
);

  generate
    if (RAM_LAT != 1) begin : g_ram_lat_check
      $error("tawas_ls: only RAM_LAT == 1 is supported");
    end
  endgenerate

  // ---------------------------------------------------------------- decode
  logic [2:0]  op;
  logic [5:0]  off6;
  logic [31:0] off_ext;
  logic [1:0]  size;         // 0 byte, 1 half, 2 word
  logic        is_store;
  logic        upd_ptr;
  logic [31:0] sum;
  logic [31:0] addr_d;
  logic        misalign;
  logic        go;
  logic        fault_d;
  logic [3:0]  dmask_d;
  logic [31:0] dout_d;

  assign op       = bus.LS_OP[14:12];
  assign off6     = bus.LS_OP[11:6];
  assign off_ext  = {{26{off6[5]}}, off6};
  assign is_store = op[2];
  assign upd_ptr  = (op == 3'd3) || (op == 3'd7);

  assign bus.REG_PTR_SEL  = bus.LS_OP[5:3];
  assign bus.REG_DATA_SEL = bus.LS_OP[2:0];

  always_comb begin
    case (op[1:0])
      2'd0:    size = 2'd0;
      2'd1:    size = 2'd1;
      default: size = 2'd2;
    endcase
  end

  // Offset is scaled by access size. Post-increment (op 3) accesses the old
  // pointer; every other op, including pre-update (op 7), accesses the sum.
  // The sum is also the new pointer value for both op 3 and op 7.
  assign sum    = bus.PTR_DATA + (off_ext << size);
  assign addr_d = (op == 3'd3) ? bus.PTR_DATA : sum;

  assign misalign = ((size == 2'd1) && addr_d[0]) ||
                    ((size == 2'd2) && (addr_d[1:0] != 2'b00));
  assign go       = bus.LS_OP_VLD && !misalign;
  assign fault_d  = bus.LS_OP_VLD && misalign;

  always_comb begin
    dmask_d = 4'hF;
    dout_d  = 32'h0;
    case (size)
      2'd0:    dmask_d = 4'b0001 << addr_d[1:0];
      2'd1:    dmask_d = addr_d[1] ? 4'b1100 : 4'b0011;
      default: dmask_d = 4'hF;
    endcase
    // Stores replicate the datum across all lanes; DMASK picks the live ones.
    if (is_store) begin
      case (size)
        2'd0:    dout_d = {4{bus.STORE_DATA[7:0]}};
        2'd1:    dout_d = {2{bus.STORE_DATA[15:0]}};
        default: dout_d = bus.STORE_DATA;
      endcase
    end
  end

  // ------------------------------------------------------------- registers
  logic        dcs_q, dwr_q;
  logic [31:0] daddr_q;
  logic [3:0]  dmask_q;
  logic [31:0] dout_q;
  logic        ptr_wb_vld_q, ptr_wb_slice_q;
  logic [2:0]  ptr_wb_reg_q;
  logic [31:0] ptr_wb_data_q;
  logic        fault_q, fault_slice_q;
  // Load bookkeeping while the RAM read is in flight (T+1).
  logic        s1_slice_q;
  logic [2:0]  s1_reg_q;
  logic [1:0]  s1_size_q;
  // Load write-back stage (T+2).
  logic        wb_vld_q, wb_slice_q;
  logic [2:0]  wb_reg_q;
  logic [1:0]  wb_lo_q;
  logic [1:0]  wb_size_q;
  logic        ld_issue;

  assign ld_issue = dcs_q && !dwr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dcs_q          <= 1'b0;
      dwr_q          <= 1'b0;
      daddr_q        <= 32'h0;
      dmask_q        <= 4'h0;
      dout_q         <= 32'h0;
      ptr_wb_vld_q   <= 1'b0;
      ptr_wb_slice_q <= 1'b0;
      ptr_wb_reg_q   <= 3'h0;
      ptr_wb_data_q  <= 32'h0;
      fault_q        <= 1'b0;
      fault_slice_q  <= 1'b0;
      s1_slice_q     <= 1'b0;
      s1_reg_q       <= 3'h0;
      s1_size_q      <= 2'h0;
      wb_vld_q       <= 1'b0;
      wb_slice_q     <= 1'b0;
      wb_reg_q       <= 3'h0;
      wb_lo_q        <= 2'h0;
      wb_size_q      <= 2'h0;
    end else begin
      dcs_q        <= go;
      dwr_q        <= go && is_store;
      ptr_wb_vld_q <= go && upd_ptr;
      fault_q      <= fault_d;
      wb_vld_q     <= ld_issue;

      // Bus address/mask/data hold their last value when nothing issues.
      if (go) begin
        daddr_q <= addr_d;
        dmask_q <= dmask_d;
        dout_q  <= dout_d;
      end
      if (go && upd_ptr) begin
        ptr_wb_slice_q <= bus.SLICE;
        ptr_wb_reg_q   <= bus.LS_OP[5:3];
        ptr_wb_data_q  <= sum;
      end
      if (fault_d) begin
        fault_slice_q <= bus.SLICE;
      end
      if (go && !is_store) begin
        s1_slice_q <= bus.SLICE;
        s1_reg_q   <= bus.LS_OP[2:0];
        s1_size_q  <= size;
      end
      if (ld_issue) begin
        wb_slice_q <= s1_slice_q;
        wb_reg_q   <= s1_reg_q;
        wb_lo_q    <= daddr_q[1:0];
        wb_size_q  <= s1_size_q;
      end
    end
  end

  // ---------------------------------------------------- load data format
  logic [31:0] din_shift;
  logic [31:0] wb_data_d;

  assign din_shift = bus.DIN >> {wb_lo_q, 3'b000};

  always_comb begin
    wb_data_d = bus.DIN;
    case (wb_size_q)
      2'd0:    wb_data_d = {24'h0, din_shift[7:0]};
      2'd1:    wb_data_d = {16'h0, din_shift[15:0]};
      default: wb_data_d = bus.DIN;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  assign bus.DCS          = dcs_q;
  assign bus.DWR          = dwr_q;
  assign bus.DADDR        = daddr_q;
  assign bus.DMASK        = dmask_q;
  assign bus.DOUT         = dout_q;
  assign bus.WB_VLD       = wb_vld_q;
  assign bus.WB_SLICE     = wb_slice_q;
  assign bus.WB_REG       = wb_reg_q;
  assign bus.WB_DATA      = wb_data_d;
  assign bus.PTR_WB_VLD   = ptr_wb_vld_q;
  assign bus.PTR_WB_SLICE = ptr_wb_slice_q;
  assign bus.PTR_WB_REG   = ptr_wb_reg_q;
  assign bus.PTR_WB_DATA  = ptr_wb_data_q;
  assign bus.LS_FAULT     = fault_q;
  assign bus.FAULT_SLICE  = fault_slice_q;

endmodule

// File: tb/tb_tawas_ls.sv
// tb_tawas_ls: directed-vector bench for tawas_ls with hand-computed results.
module tb_tawas_ls;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  tawas_ls_if bus ();

  tawas_ls #(.RAM_LAT(1)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic drive_op(input logic sl, input logic [2:0] op, input logic [5:0] off,
                          input logic [2:0] pr, input logic [2:0] dr,
                          input logic [31:0] ptr, input logic [31:0] sd);
    bus.SLICE      = sl;
    bus.LS_OP_VLD  = 1'b1;
    bus.LS_OP      = {op, off, pr, dr};
    bus.PTR_DATA   = ptr;
    bus.STORE_DATA = sd;
  endtask

  task automatic idle();
    bus.LS_OP_VLD  = 1'b0;
    bus.LS_OP      = 15'h0;
    bus.PTR_DATA   = 32'h0;
    bus.STORE_DATA = 32'h0;
  endtask

  initial begin
    RST_N   = 1'b0;
    bus.SLICE = 1'b0;
    bus.DIN   = 32'h0;
    idle();

    // ---- reset state
    repeat (2) @(negedge CLK);
    chk("rst DCS", {31'h0, bus.DCS}, 32'h0);
    chk("rst WB_VLD", {31'h0, bus.WB_VLD}, 32'h0);
    chk("rst PTR_WB_VLD", {31'h0, bus.PTR_WB_VLD}, 32'h0);
    chk("rst LS_FAULT", {31'h0, bus.LS_FAULT}, 32'h0);
    chk("rst DADDR", bus.DADDR, 32'h0);
    chk("rst DMASK", {28'h0, bus.DMASK}, 32'h0);
    RST_N = 1'b1;
    @(negedge CLK);

    // ---- reset mid-load: op 2 at T, reset asserted during T+1
    drive_op(1'b0, 3'd2, 6'd0, 3'd1, 3'd4, 32'h0000_0100, 32'h0);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    idle();
    #1;
    chk("midrst DCS", {31'h0, bus.DCS}, 32'h0);
    chk("midrst DADDR", bus.DADDR, 32'h0);
    @(negedge CLK);
    chk("midrst WB_VLD T+2", {31'h0, bus.WB_VLD}, 32'h0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("midrst WB_VLD after", {31'h0, bus.WB_VLD}, 32'h0);

    // ---- load byte, zero-extended, lane 3
    drive_op(1'b0, 3'd0, 6'd0, 3'd1, 3'd2, 32'h0000_1003, 32'h0);
    #1;
    chk("lb REG_PTR_SEL", {29'h0, bus.REG_PTR_SEL}, 32'd1);
    chk("lb REG_DATA_SEL", {29'h0, bus.REG_DATA_SEL}, 32'd2);
    @(negedge CLK);
    idle();
    chk("lb DCS", {31'h0, bus.DCS}, 32'h1);
    chk("lb DWR", {31'h0, bus.DWR}, 32'h0);
    chk("lb DADDR", bus.DADDR, 32'h0000_1003);
    chk("lb DMASK", {28'h0, bus.DMASK}, 32'h8);
    chk("lb DOUT", bus.DOUT, 32'h0);
    bus.DIN = 32'hAB00_0000;
    @(negedge CLK);
    chk("lb WB_VLD", {31'h0, bus.WB_VLD}, 32'h1);
    chk("lb WB_DATA", bus.WB_DATA, 32'h0000_00AB);
    chk("lb WB_REG", {29'h0, bus.WB_REG}, 32'd2);
    chk("lb DCS off", {31'h0, bus.DCS}, 32'h0);

    // ---- push, slice 1: op 7, off -1
    drive_op(1'b1, 3'd7, 6'h3F, 3'd6, 3'd7, 32'h0000_2000, 32'hDEAD_BEEF);
    @(negedge CLK);
    idle();
    chk("push DCS", {31'h0, bus.DCS}, 32'h1);
    chk("push DWR", {31'h0, bus.DWR}, 32'h1);
    chk("push DADDR", bus.DADDR, 32'h0000_1FFC);
    chk("push DMASK", {28'h0, bus.DMASK}, 32'hF);
    chk("push DOUT", bus.DOUT, 32'hDEAD_BEEF);
    chk("push PTR_WB_VLD", {31'h0, bus.PTR_WB_VLD}, 32'h1);
    chk("push PTR_WB_DATA", bus.PTR_WB_DATA, 32'h0000_1FFC);
    chk("push PTR_WB_SLICE", {31'h0, bus.PTR_WB_SLICE}, 32'h1);
    chk("push PTR_WB_REG", {29'h0, bus.PTR_WB_REG}, 32'd6);
    @(negedge CLK);
    chk("push no WB_VLD", {31'h0, bus.WB_VLD}, 32'h0);
    chk("push PTR_WB_VLD off", {31'h0, bus.PTR_WB_VLD}, 32'h0);

    // ---- pop, slice 1: op 3, off +1
    drive_op(1'b1, 3'd3, 6'd1, 3'd6, 3'd7, 32'h0000_1FFC, 32'h0);
    @(negedge CLK);
    idle();
    chk("pop DCS", {31'h0, bus.DCS}, 32'h1);
    chk("pop DWR", {31'h0, bus.DWR}, 32'h0);
    chk("pop DADDR", bus.DADDR, 32'h0000_1FFC);
    chk("pop PTR_WB_VLD", {31'h0, bus.PTR_WB_VLD}, 32'h1);
    chk("pop PTR_WB_DATA", bus.PTR_WB_DATA, 32'h0000_2000);
    bus.DIN = 32'h1234_5678;
    @(negedge CLK);
    chk("pop WB_VLD", {31'h0, bus.WB_VLD}, 32'h1);
    chk("pop WB_DATA", bus.WB_DATA, 32'h1234_5678);
    chk("pop WB_REG", {29'h0, bus.WB_REG}, 32'd7);
    chk("pop WB_SLICE", {31'h0, bus.WB_SLICE}, 32'h1);

    // ---- misaligned store half, slice 0
    drive_op(1'b0, 3'd5, 6'd0, 3'd2, 3'd3, 32'h0000_0001, 32'h5555_AAAA);
    @(negedge CLK);
    idle();
    chk("mis DCS", {31'h0, bus.DCS}, 32'h0);
    chk("mis LS_FAULT", {31'h0, bus.LS_FAULT}, 32'h1);
    chk("mis FAULT_SLICE", {31'h0, bus.FAULT_SLICE}, 32'h0);
    chk("mis PTR_WB_VLD", {31'h0, bus.PTR_WB_VLD}, 32'h0);
    chk("mis DADDR hold", bus.DADDR, 32'h0000_1FFC);
    @(negedge CLK);
    chk("mis LS_FAULT off", {31'h0, bus.LS_FAULT}, 32'h0);
    chk("mis WB_VLD", {31'h0, bus.WB_VLD}, 32'h0);

    // ---- misaligned word load, slice 1
    drive_op(1'b1, 3'd2, 6'd0, 3'd2, 3'd3, 32'h0000_0102, 32'h0);
    @(negedge CLK);
    idle();
    chk("misw LS_FAULT", {31'h0, bus.LS_FAULT}, 32'h1);
    chk("misw FAULT_SLICE", {31'h0, bus.FAULT_SLICE}, 32'h1);
    chk("misw DCS", {31'h0, bus.DCS}, 32'h0);
    @(negedge CLK);
    chk("misw WB_VLD", {31'h0, bus.WB_VLD}, 32'h0);

    // ---- interleave + wrap: slice 0 load word at T, slice 1 store byte at T+1
    drive_op(1'b0, 3'd2, 6'd1, 3'd1, 3'd3, 32'hFFFF_FFFC, 32'h0);
    @(negedge CLK);
    chk("ilv ld DCS", {31'h0, bus.DCS}, 32'h1);
    chk("ilv ld DWR", {31'h0, bus.DWR}, 32'h0);
    chk("ilv ld DADDR wrap", bus.DADDR, 32'h0000_0000);
    drive_op(1'b1, 3'd4, 6'd0, 3'd2, 3'd5, 32'h0000_3002, 32'h0000_00C5);
    bus.DIN = 32'hCAFE_F00D;
    @(negedge CLK);
    idle();
    chk("ilv st DCS", {31'h0, bus.DCS}, 32'h1);
    chk("ilv st DWR", {31'h0, bus.DWR}, 32'h1);
    chk("ilv st DADDR", bus.DADDR, 32'h0000_3002);
    chk("ilv st DMASK", {28'h0, bus.DMASK}, 32'h4);
    chk("ilv st DOUT", bus.DOUT, 32'hC5C5_C5C5);
    chk("ilv WB_VLD", {31'h0, bus.WB_VLD}, 32'h1);
    chk("ilv WB_SLICE", {31'h0, bus.WB_SLICE}, 32'h0);
    chk("ilv WB_REG", {29'h0, bus.WB_REG}, 32'd3);
    chk("ilv WB_DATA", bus.WB_DATA, 32'hCAFE_F00D);
    @(negedge CLK);
    chk("ilv DCS off", {31'h0, bus.DCS}, 32'h0);
    chk("ilv WB_VLD off", {31'h0, bus.WB_VLD}, 32'h0);

    // ---- load half, upper lane: ptr 0x10 + (1<<1) = 0x12
    drive_op(1'b0, 3'd1, 6'd1, 3'd0, 3'd4, 32'h0000_0010, 32'h0);
    @(negedge CLK);
    idle();
    chk("lh DADDR", bus.DADDR, 32'h0000_0012);
    chk("lh DMASK", {28'h0, bus.DMASK}, 32'hC);
    bus.DIN = 32'h8765_4321;
    @(negedge CLK);
    chk("lh WB_DATA", bus.WB_DATA, 32'h0000_8765);
    chk("lh WB_REG", {29'h0, bus.WB_REG}, 32'd4);

    // ---- store half, negative offset: 0x20 + (-1<<1) = 0x1E
    drive_op(1'b0, 3'd5, 6'h3F, 3'd0, 3'd1, 32'h0000_0020, 32'h1234_ABCD);
    @(negedge CLK);
    idle();
    chk("sh DADDR", bus.DADDR, 32'h0000_001E);
    chk("sh DMASK", {28'h0, bus.DMASK}, 32'hC);
    chk("sh DOUT", bus.DOUT, 32'hABCD_ABCD);
    chk("sh PTR_WB_VLD", {31'h0, bus.PTR_WB_VLD}, 32'h0);

    // ---- load byte lane 1 with word-scaled check of zero extension
    drive_op(1'b1, 3'd0, 6'd1, 3'd0, 3'd6, 32'h0000_0040, 32'h0);
    @(negedge CLK);
    idle();
    chk("lb1 DADDR", bus.DADDR, 32'h0000_0041);
    chk("lb1 DMASK", {28'h0, bus.DMASK}, 32'h2);
    bus.DIN = 32'h11F2_9933;
    @(negedge CLK);
    chk("lb1 WB_DATA", bus.WB_DATA, 32'h0000_0099);
    chk("lb1 WB_SLICE", {31'h0, bus.WB_SLICE}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
